// File: rtl/discrete_i2s_sample_tx.sv
// rtl/discrete_i2s_sample_tx.sv - FIFO-buffered mono sample to stereo I2S serializer
// Define I2S_TX_LEFT_JUSTIFIED_EN for left-justified alignment (default: standard I2S).
module discrete_i2s_sample_tx #(
    parameter int BCLK_HALF  = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int LEVEL_W    = 3
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               audio_clk_en,
    input  logic signed [15:0] sample_in,
    input  logic               clear_flags,
    output logic               i2s_bclk,
    output logic               i2s_lrck,
    output logic               i2s_data,
    output logic [LEVEL_W-1:0] fifo_level,
    output logic               overflow,
    output logic               underrun
);
    localparam int DIV_W = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [DIV_W-1:0]   DIV_MAX  = DIV_W'(BCLK_HALF - 1);
    localparam logic [LEVEL_W-1:0] LVL_FULL = LEVEL_W'(FIFO_DEPTH);

    // IDLE means no frame has started since reset; the first fall event opens slot 0
    typedef enum logic {ST_IDLE, ST_RUN} state_t;
    state_t state, state_nxt;

    logic [DIV_W-1:0] div_cnt;
    logic [4:0]       slot_cnt, slot_nxt;
    logic             fall_evt, frame_start, half_start;
    logic [15:0]      held, shift_reg, word_nxt;
    logic [15:0]      mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             fifo_empty, fifo_full, do_push, do_pop, push_drop;

    assign fall_evt = (div_cnt == DIV_MAX) && i2s_bclk;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt  <= '0;
            i2s_bclk <= 1'b0;
        end else if (div_cnt == DIV_MAX) begin
            div_cnt  <= '0;
            i2s_bclk <= ~i2s_bclk;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        slot_nxt    = slot_cnt;
        frame_start = 1'b0;
        half_start  = 1'b0;
        if (fall_evt) begin
            if (state == ST_IDLE) begin
                state_nxt   = ST_RUN;
                slot_nxt    = 5'd0;
                frame_start = 1'b1;
            end else begin
                slot_nxt    = slot_cnt + 5'd1;
                frame_start = (slot_cnt == 5'd31);
            end
            half_start = (slot_nxt[3:0] == 4'd0);
        end
    end

    assign fifo_empty = (fifo_level == '0);
    assign fifo_full  = (fifo_level == LVL_FULL);
    assign do_pop     = frame_start && !fifo_empty;
    // A simultaneous pop frees the slot, so a push into a full FIFO is accepted then
    assign do_push    = audio_clk_en && (!fifo_full || do_pop);
    assign push_drop  = audio_clk_en && fifo_full && !do_pop;
    assign word_nxt   = do_pop ? mem[rd_ptr] : held;

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= sample_in;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (do_push && !do_pop)      fifo_level <= fifo_level + LEVEL_W'(1);
            else if (do_pop && !do_push) fifo_level <= fifo_level - LEVEL_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_cnt  <= '0;
            i2s_lrck  <= 1'b0;
            i2s_data  <= 1'b0;
            held      <= '0;
            shift_reg <= '0;
        end else if (fall_evt) begin
            slot_cnt <= slot_nxt;
            i2s_lrck <= slot_nxt[4];
            if (frame_start) held <= word_nxt;
`ifdef I2S_TX_LEFT_JUSTIFIED_EN
            if (half_start) begin
                i2s_data  <= word_nxt[15];
                shift_reg <= {word_nxt[14:0], 1'b0};
            end else begin
                i2s_data  <= shift_reg[15];
                shift_reg <= {shift_reg[14:0], 1'b0};
            end
`else
            // Slot 0 emits the LSB left over from the previous half-word
            i2s_data <= shift_reg[15];
            if (half_start) shift_reg <= word_nxt;
            else            shift_reg <= {shift_reg[14:0], 1'b0};
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
            underrun <= 1'b0;
        end else begin
            if (push_drop)        overflow <= 1'b1;
            else if (clear_flags) overflow <= 1'b0;
            if (frame_start && fifo_empty) underrun <= 1'b1;
            else if (clear_flags)          underrun <= 1'b0;
        end
    end
endmodule

// File: tb/tb_discrete_i2s_sample_tx.sv
// tb/tb_discrete_i2s_sample_tx.sv - directed bench for discrete_i2s_sample_tx with I2S receiver model
module tb_discrete_i2s_sample_tx;
    localparam int BCLK_HALF = 4;
    localparam int N_VEC     = 7;

    logic        clk;
    logic        reset_n;
    logic        audio_clk_en;
    logic [15:0] sample_in;
    logic        clear_flags;
    logic        i2s_bclk, i2s_lrck, i2s_data;
    logic [2:0]  fifo_level;
    logic        overflow, underrun;

    discrete_i2s_sample_tx #(.BCLK_HALF(BCLK_HALF), .FIFO_DEPTH(4), .LEVEL_W(3)) dut (
        .clk(clk), .reset_n(reset_n), .audio_clk_en(audio_clk_en),
        .sample_in(sample_in), .clear_flags(clear_flags),
        .i2s_bclk(i2s_bclk), .i2s_lrck(i2s_lrck), .i2s_data(i2s_data),
        .fifo_level(fifo_level), .overflow(overflow), .underrun(underrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

`ifdef I2S_TX_LEFT_JUSTIFIED_EN
    localparam logic FIRST_BIT_EXP = 1'b1;
`else
    localparam logic FIRST_BIT_EXP = 1'b0;
`endif

    // Receiver model: tracks slots on bclk falls, samples data/lrck on bclk rises
    int          m_frame = -1;
    int          m_slot = -1;
    int          cyc = 0;
    int          last_rise = 0;
    int          lrck_per = 0;
    int          lrck_bad = 0;
    logic        bclk_q = 1'b0;
    logic        lrck_q = 1'b0;
    logic        first_bit = 1'bx;
    logic [15:0] sh = '0;
    logic [15:0] fl [0:63];
    logic [15:0] fr [0:63];

    always @(negedge clk) begin
        cyc++;
        if (!reset_n) begin
            m_frame = -1; m_slot = -1; bclk_q = 1'b0; lrck_q = 1'b0; first_bit = 1'bx;
        end else begin
            if (bclk_q && !i2s_bclk) begin
                if (m_slot < 0 || m_slot == 31) begin
                    m_slot = 0;
                    m_frame++;
                end else begin
                    m_slot++;
                end
            end
            if (!bclk_q && i2s_bclk && m_slot >= 0 && m_frame < 64) begin
                if (i2s_lrck !== (m_slot >= 16)) lrck_bad++;
                if (m_frame == 0 && m_slot == 0) first_bit = i2s_data;
`ifdef I2S_TX_LEFT_JUSTIFIED_EN
                sh[15 - (m_slot % 16)] = i2s_data;
                if (m_slot == 15) fl[m_frame] = sh;
                if (m_slot == 31) fr[m_frame] = sh;
`else
                if (m_slot % 16 == 0) begin
                    sh[0] = i2s_data;
                    if (m_slot == 16)     fl[m_frame] = sh;
                    else if (m_frame > 0) fr[m_frame - 1] = sh;
                end else begin
                    sh[16 - (m_slot % 16)] = i2s_data;
                end
`endif
            end
            if (i2s_lrck && !lrck_q) begin
                lrck_per  = cyc - last_rise;
                last_rise = cyc;
            end
            bclk_q = i2s_bclk;
            lrck_q = i2s_lrck;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_pos(input int f, input int s);
        int n = 0;
        while (m_frame * 32 + m_slot < f * 32 + s) begin
            @(negedge clk); #1;
            n++;
            if (n > 20000) begin
                checks++;
                errors++;
                $display("FAIL wait_pos: timeout waiting for frame %0d slot %0d", f, s);
                return;
            end
        end
    endtask

    task automatic push(input logic [15:0] d);
        audio_clk_en = 1'b1;
        sample_in    = d;
        @(negedge clk); #1;
        audio_clk_en = 1'b0;
    endtask

    task automatic pulse_clear();
        clear_flags = 1'b1;
        @(negedge clk); #1;
        clear_flags = 1'b0;
    endtask

    typedef struct {
        logic [15:0] sample;
        logic [15:0] exp_word;
        logic [2:0]  exp_lvl;
    } vec_t;
    vec_t vecs [N_VEC];

    initial begin
        vecs[0] = '{16'h1234, 16'h1234, 3'd1};
        vecs[1] = '{16'h5678, 16'h5678, 3'd1};
        vecs[2] = '{16'hABCD, 16'hABCD, 3'd1};
        vecs[3] = '{16'h0000, 16'h0000, 3'd1};
        vecs[4] = '{16'hFFFF, 16'hFFFF, 3'd1};
        vecs[5] = '{16'h8000, 16'h8000, 3'd1};
        vecs[6] = '{16'h7FFF, 16'h7FFF, 3'd1};

        reset_n = 1'b0; audio_clk_en = 1'b0; sample_in = '0; clear_flags = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_bclk", i2s_bclk, 0);
        chk("rst_lrck", i2s_lrck, 0);
        chk("rst_data", i2s_data, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_underrun", underrun, 0);

        // First sample: popped at the very first frame start
        @(negedge clk);
        reset_n = 1'b1;
        push(16'h8001);
        chk("t1_level_push", fifo_level, 1);
        wait_pos(0, 2);
        chk("t1_level_pop", fifo_level, 0);
        chk("t1_underrun0", underrun, 0);
        wait_pos(1, 2);
        chk("t1_underrun_empty", underrun, 1);
        chk("t1_first_slot0", first_bit, FIRST_BIT_EXP);
        chk("t1_left", fl[0], 16'h8001);
        chk("t1_right", fr[0], 16'h8001);
        wait_pos(2, 20);
        chk("t1_lrck_period", lrck_per, 64 * BCLK_HALF);

        // Streaming: one push per frame, each popped at the following frame start
        for (int i = 0; i < N_VEC; i++) begin
            wait_pos(2 + i, 20);
            if (i == 0) begin
                pulse_clear();
                chk("stream_clear_underrun", underrun, 0);
            end
            push(vecs[i].sample);
            chk("stream_level_push", fifo_level, vecs[i].exp_lvl);
            wait_pos(3 + i, 2);
            chk("stream_level_pop", fifo_level, 0);
        end
        chk("stream_overflow", overflow, 0);
        chk("stream_underrun", underrun, 0);
        wait_pos(3 + N_VEC, 2);
        chk("udr_set", underrun, 1);
        chk("udr_level", fifo_level, 0);
        for (int i = 0; i < N_VEC; i++) begin
            chk("stream_left", fl[3 + i], vecs[i].exp_word);
            chk("stream_right", fr[3 + i], vecs[i].exp_word);
        end

        // Underrun: 7FFF repeats over frames 10..12, then clear and resume pushes
        wait_pos(12, 20);
        pulse_clear();
        chk("udr_cleared", underrun, 0);
        push(16'h1111);
        wait_pos(13, 20);
        chk("udr_stays0_a", underrun, 0);
        push(16'h2222);
        wait_pos(14, 2);
        chk("udr_stays0_b", underrun, 0);
        wait_pos(15, 2);
        for (int f = 10; f <= 12; f++) begin
            chk("udr_repeat_left", fl[f], 16'h7FFF);
            chk("udr_repeat_right", fr[f], 16'h7FFF);
        end
        chk("resume_left_a", fl[13], 16'h1111);
        chk("resume_left_b", fl[14], 16'h2222);

        // Overflow: six back-to-back pushes into a depth-4 FIFO
        wait_pos(15, 4);
        audio_clk_en = 1'b1;
        for (int j = 1; j <= 6; j++) begin
            sample_in = 16'hA000 + 16'(j);
            @(negedge clk); #1;
        end
        audio_clk_en = 1'b0;
        chk("ovf_level", fifo_level, 4);
        chk("ovf_set", overflow, 1);
        wait_pos(15, 10);
        pulse_clear();
        chk("ovf_cleared", overflow, 0);

        // Push exactly on the frame-start pop cycle while full
        wait_pos(15, 31);
        repeat (2 * BCLK_HALF - 1) @(negedge clk);
        audio_clk_en = 1'b1;
        sample_in    = 16'hA007;
        @(negedge clk); #1;
        audio_clk_en = 1'b0;
        chk("coincide_pos", m_frame * 32 + m_slot, 16 * 32);
        chk("coincide_level", fifo_level, 4);
        chk("coincide_overflow", overflow, 0);
        wait_pos(22, 2);
        chk("ovf_frame16", fl[16], 16'hA001);
        chk("ovf_frame17", fl[17], 16'hA002);
        chk("ovf_frame18", fl[18], 16'hA003);
        chk("ovf_frame19", fl[19], 16'hA004);
        chk("ovf_frame20", fl[20], 16'hA007);
        chk("ovf_frame20_r", fr[20], 16'hA007);
        chk("ovf_frame21_repeat", fl[21], 16'hA007);
        chk("lrck_per_slot", lrck_bad, 0);

        // Reset mid-frame at slot 9 with two samples queued
        wait_pos(22, 5);
        push(16'h5555);
        push(16'h6666);
        chk("mid_level", fifo_level, 2);
        wait_pos(22, 9);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_bclk", i2s_bclk, 0);
        chk("mid_rst_lrck", i2s_lrck, 0);
        chk("mid_rst_data", i2s_data, 0);
        chk("mid_rst_level", fifo_level, 0);
        chk("mid_rst_overflow", overflow, 0);
        chk("mid_rst_underrun", underrun, 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        push(16'h8001);
        chk("post_rst_level", fifo_level, 1);
        wait_pos(0, 2);
        chk("post_rst_underrun", underrun, 0);
        wait_pos(1, 2);
        chk("post_rst_first_slot0", first_bit, FIRST_BIT_EXP);
        chk("post_rst_left", fl[0], 16'h8001);
        chk("post_rst_right", fr[0], 16'h8001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
